// File: rtl/pipelined_barrel_rotator.sv
// pipelined_barrel_rotator: log-depth rotate/shift pipeline with valid/ready flow control.
// One registered stage per rotation bit; bubbles collapse and stalls back-pressure.
//
// Ports:
//   clk, reset_n              clock, synchronous active-low reset
//   in_valid, in_ready        input handshake
//   data_in                   operand, zero-extended to OUTPUTWIDTH
//   rotation                  move amount in steps of SHIFTBITS_PER_STEP bits
//   dir_left                  0 = right, 1 = left
//   shift_mode                0 = rotate, 1 = logical shift
//   out_valid, out_ready      output handshake
//   data_out                  registered result of the last stage
module pipelined_barrel_rotator #(
  parameter int INPUTWIDTH = 32,
  parameter int OUTPUTWIDTH = 64,
  parameter int SHIFTBITS_PER_STEP = 8,
  localparam int NUM_STEPS = OUTPUTWIDTH / SHIFTBITS_PER_STEP,
  localparam int ROT_BITS = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INPUTWIDTH-1:0]  data_in,
  input  logic [ROT_BITS-1:0]    rotation,
  input  logic                   dir_left,
  input  logic                   shift_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUTPUTWIDTH-1:0] data_out
);

  localparam int OW = OUTPUTWIDTH;
  localparam int LAST = ROT_BITS - 1;

  if ((OUTPUTWIDTH % SHIFTBITS_PER_STEP) != 0 ||
      INPUTWIDTH > OUTPUTWIDTH ||
      NUM_STEPS < 1 ||
      (NUM_STEPS & (NUM_STEPS - 1)) != 0) begin : g_bad_params
    $error("pipelined_barrel_rotator: illegal parameter set");
  end

  logic [ROT_BITS-1:0]               v_q;
  logic [ROT_BITS-1:0]               adv;
  logic [ROT_BITS-1:0]               nxt_v;
  logic [OW-1:0]                     data_q   [ROT_BITS];
  logic [OW-1:0]                     nxt_data [ROT_BITS];
  logic [ROT_BITS-1:0][ROT_BITS-1:0] rot_q;
  logic [ROT_BITS-1:0][ROT_BITS-1:0] nxt_rot;
  logic [ROT_BITS-1:0]               dir_q;
  logic [ROT_BITS-1:0]               nxt_dir;
  logic [ROT_BITS-1:0]               mode_q;
  logic [ROT_BITS-1:0]               nxt_mode;
  logic [OW-1:0]                     zext;
  logic                              unused_meta;

  // Stage k moves by 2^k steps when its rotation bit is set.
  // A single-step field can only be moved by the full width, which
  // is meaningless, so rotation is ignored in that case.
  function automatic logic [OW-1:0] move(
    input logic [OW-1:0]       d,
    input int                  k,
    input logic [ROT_BITS-1:0] r,
    input logic                left,
    input logic                shf
  );
    int            amt;
    logic [OW-1:0] res;
    amt = (1 << k) * SHIFTBITS_PER_STEP;
    res = d;
    if (r[k] && (NUM_STEPS > 1)) begin
      if (left) begin
        res = d << amt;
        if (!shf) res = res | (d >> (OW - amt));
      end else begin
        res = d >> amt;
        if (!shf) res = res | (d << (OW - amt));
      end
    end
    return res;
  endfunction

  always_comb begin
    zext = '0;
    zext[INPUTWIDTH-1:0] = data_in;
  end

  // A stage advances when any stage from itself to the end is empty,
  // or the consumer takes the result; this is the unrolled ready chain.
  always_comb begin
    logic full;
    adv = '0;
    for (int k = 0; k < ROT_BITS; k++) begin
      full = 1'b1;
      for (int j = k; j < ROT_BITS; j++) full = full & v_q[j];
      adv[k] = out_ready | ~full;
    end
  end

  always_comb begin
    nxt_v       = '0;
    nxt_rot     = '0;
    nxt_dir     = '0;
    nxt_mode    = '0;
    nxt_v[0]    = in_valid;
    nxt_rot[0]  = rotation;
    nxt_dir[0]  = dir_left;
    nxt_mode[0] = shift_mode;
    nxt_data[0] = move(zext, 0, rotation, dir_left, shift_mode);
    for (int k = 1; k < ROT_BITS; k++) begin
      nxt_v[k]    = v_q[k-1];
      nxt_rot[k]  = rot_q[k-1];
      nxt_dir[k]  = dir_q[k-1];
      nxt_mode[k] = mode_q[k-1];
      nxt_data[k] = move(data_q[k-1], k, rot_q[k-1],
                         dir_q[k-1], mode_q[k-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v_q    <= '0;
      rot_q  <= '0;
      dir_q  <= '0;
      mode_q <= '0;
      for (int k = 0; k < ROT_BITS; k++) data_q[k] <= '0;
    end else begin
      for (int k = 0; k < ROT_BITS; k++) begin
        if (adv[k]) begin
          v_q[k]    <= nxt_v[k];
          data_q[k] <= nxt_data[k];
          rot_q[k]  <= nxt_rot[k];
          dir_q[k]  <= nxt_dir[k];
          mode_q[k] <= nxt_mode[k];
        end
      end
    end
  end

  assign in_ready  = reset_n & adv[0];
  assign out_valid = v_q[LAST];
  assign data_out  = data_q[LAST];

  // Last-stage control fields travel with the data but have no consumer.
  assign unused_meta = ^{rot_q, dir_q, mode_q};

endmodule

// File: tb/tb_pipelined_barrel_rotator.sv
// tb_pipelined_barrel_rotator: randomized and directed checks of the rotator
// against an arithmetic reference model and a scoreboard queue.
module tb_pipelined_barrel_rotator;

  localparam int IW = 32;
  localparam int OW = 64;
  localparam int RB = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] data_in;
  logic [RB-1:0] rotation;
  logic          dir_left;
  logic          shift_mode;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] data_out;

  int total = 0;
  int bad = 0;
  logic [OW-1:0] exp_q[$];

  pipelined_barrel_rotator #(
    .INPUTWIDTH(IW),
    .OUTPUTWIDTH(OW),
    .SHIFTBITS_PER_STEP(8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .data_in(data_in),
    .rotation(rotation),
    .dir_left(dir_left),
    .shift_mode(shift_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out(data_out)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(
    input logic [31:0] d,
    input int          rot,
    input logic        left,
    input logic        shf
  );
    logic [127:0] dbl;
    logic [63:0]  x;
    int           amt;
    x = 64'(d);
    amt = rot * 8;
    if (shf) return left ? (x << amt) : (x >> amt);
    dbl = {x, x};
    if (left) begin
      dbl = dbl << amt;
      return dbl[127:64];
    end
    dbl = dbl >> amt;
    return dbl[63:0];
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    in_valid = 1'b1;
    data_in = $urandom;
    rotation = 3'd2;
    dir_left = 1'b0;
    shift_mode = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_in_ready got=%b want=0", in_ready);
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_out_valid got=%b want=0", out_valid);
    end
    total++;
    if (data_out !== 64'h0) begin
      bad++;
      $display("FAIL reset_data_out got=%h want=0", data_out);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL release_in_ready got=%b want=1", in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL reset_ghost cyc=%0d got=%b want=0", i, out_valid);
      end
    end
  endtask

  task automatic test_directed();
    logic [63:0] exp_tab [5];
    logic [2:0]  rot_tab [5];
    logic        lft_tab [5];
    logic        shf_tab [5];
    int          lat;
    exp_tab = '{64'hf000000000aa5533, 64'h000000aa5533f000,
                64'haa5533f000000000, 64'h0000000000aa5533,
                64'hf000000000000000};
    rot_tab = '{3'd1, 3'd1, 3'd4, 3'd1, 3'd7};
    lft_tab = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    shf_tab = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int v = 0; v < 5; v++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      data_in = 32'haa5533f0;
      rotation = rot_tab[v];
      dir_left = lft_tab[v];
      shift_mode = shf_tab[v];
      out_ready = 1'b1;
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1) begin
        bad++;
        $display("FAIL dir%0d_accept got=%b want=1", v, in_ready);
      end
      lat = 0;
      for (int n = 1; n <= 10; n++) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        if (out_valid === 1'b1) begin
          lat = n;
          break;
        end
      end
      total++;
      if (lat != 3) begin
        bad++;
        $display("FAIL dir%0d_latency got=%0d want=3", v, lat);
      end
      total++;
      if (data_out !== exp_tab[v]) begin
        bad++;
        $display("FAIL dir%0d_data got=%h want=%h", v, data_out, exp_tab[v]);
      end
      total++;
      if (data_out !== model(32'haa5533f0, int'(rot_tab[v]),
                             lft_tab[v], shf_tab[v])) begin
        bad++;
        $display("FAIL dir%0d_model got=%h", v, data_out);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] e;
    logic        want_v;
    exp_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (i < 8) begin
        in_valid = 1'b1;
        data_in = $urandom;
        rotation = 3'(i);
        dir_left = 1'b0;
        shift_mode = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (in_valid && in_ready)
        exp_q.push_back(model(data_in, int'(rotation), 1'b0, 1'b0));
      if (i < 8) begin
        total++;
        if (in_ready !== 1'b1) begin
          bad++;
          $display("FAIL b2b_ready cyc=%0d got=%b want=1", i, in_ready);
        end
      end
      want_v = (i >= 3) && (i <= 10);
      total++;
      if (out_valid !== want_v) begin
        bad++;
        $display("FAIL b2b_valid cyc=%0d got=%b want=%b", i, out_valid, want_v);
      end
      if (out_valid === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL b2b_extra cyc=%0d got=%h want=none", i, data_out);
        end else begin
          e = exp_q.pop_front();
          if (data_out !== e) begin
            bad++;
            $display("FAIL b2b_data cyc=%0d got=%h want=%h", i, data_out, e);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    int          sent = 0;
    int          recv = 0;
    int          cyc = 0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data = '0;
    logic [63:0] e;
    exp_q.delete();
    while ((sent < 1000 || exp_q.size() > 0) && cyc < 30000) begin
      @(posedge clk); #1;
      in_valid = (sent < 1000) && ($urandom_range(0, 99) < 60);
      data_in = $urandom;
      rotation = 3'($urandom_range(0, 7));
      dir_left = 1'($urandom_range(0, 1));
      shift_mode = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 99) < 30);
      @(negedge clk);
      cyc++;
      if (in_valid && in_ready) begin
        exp_q.push_back(model(data_in, int'(rotation), dir_left, shift_mode));
        sent++;
      end
      if (prev_stall) begin
        total++;
        if (out_valid !== 1'b1 || data_out !== prev_data) begin
          bad++;
          $display("FAIL rnd_stall cyc=%0d got=%b/%h want=1/%h",
                   cyc, out_valid, data_out, prev_data);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rnd_extra cyc=%0d got=%h want=none", cyc, data_out);
        end else begin
          e = exp_q.pop_front();
          recv++;
          if (data_out !== e) begin
            bad++;
            $display("FAIL rnd_data cyc=%0d got=%h want=%h", cyc, data_out, e);
          end
        end
      end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      prev_data = data_out;
    end
    total++;
    if (recv != 1000) begin
      bad++;
      $display("FAIL rnd_count got=%0d want=1000 cycles=%0d", recv, cyc);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [63:0] e;
    int          cnt = 0;
    int          first = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      data_in = $urandom;
      rotation = 3'($urandom_range(0, 7));
      dir_left = 1'($urandom_range(0, 1));
      shift_mode = 1'($urandom_range(0, 1));
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1) begin
        bad++;
        $display("FAIL mid_fill cyc=%0d got=%b want=1", i, in_ready);
      end
    end
    @(posedge clk); #1;
    reset_n = 1'b0;
    data_in = $urandom;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_rst_ready got=%b want=0", in_ready);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    data_in = $urandom;
    rotation = 3'($urandom_range(0, 7));
    dir_left = 1'($urandom_range(0, 1));
    shift_mode = 1'($urandom_range(0, 1));
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || data_out !== 64'h0) begin
      bad++;
      $display("FAIL mid_cleared got=%b/%h want=0/0", out_valid, data_out);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_first_accept got=%b want=1", in_ready);
    end
    exp_q.delete();
    exp_q.push_back(model(data_in, int'(rotation), dir_left, shift_mode));
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      if (out_valid === 1'b1) begin
        cnt++;
        if (first == 0) first = n;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL mid_stale n=%0d got=%h want=none", n, data_out);
        end else begin
          e = exp_q.pop_front();
          if (data_out !== e) begin
            bad++;
            $display("FAIL mid_data got=%h want=%h", data_out, e);
          end
        end
      end
    end
    total++;
    if (cnt != 1 || first != 3) begin
      bad++;
      $display("FAIL mid_outputs got=%0d@%0d want=1@3", cnt, first);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    in_valid = 1'b0;
    data_in = '0;
    rotation = '0;
    dir_left = 1'b0;
    shift_mode = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
